// File: rtl/rf_write_queue_pkg.sv
// rf_write_queue_pkg: shared widths, depth and queue entry type for the
// register-file write queue (data width, index width, depth, entry record).
package rf_write_queue_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } entry_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

endpackage

// File: rtl/rf_write_queue_if.sv
// rf_write_queue_if: producer-side valid/ready write handshake.
// Ports: in_valid, in_ready, in_addr, in_data; master = producer, slave = queue.
interface rf_write_queue_if;
  import rf_write_queue_pkg::*;

  logic  in_valid;
  logic  in_ready;
  addr_t in_addr;
  data_t in_data;

  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/rf_wq_match.sv
// rf_wq_match: youngest-first lookup of a register index over queued entries.
// Ports: ents/head/count (queue state), q_addr in; hit, fwd_data out.
module rf_wq_match
  import rf_write_queue_pkg::*;
(
  input  entry_t ents [DEPTH],
  input  ptr_t   head,
  input  cnt_t   count,
  input  addr_t  q_addr,
  output logic   hit,
  output data_t  fwd_data
);

  ptr_t idx;

  // Walk from oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + ptr_t'(i);
      if (cnt_t'(i) < count &&
          q_addr != '0 &&
          ents[idx].addr == q_addr) begin
        hit      = 1'b1;
        fwd_data = ents[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// rf_write_queue: in-order write buffer in front of the register file write
// port, with two forwarding lookups.
// Ports: clk, rst_n; wr (slave handshake); rf_stall, rf_we, rf_waddr,
// rf_wdata; q_addr1/2, hit1/2, fwd_data1/2; count, empty.
module rf_write_queue
  import rf_write_queue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rf_write_queue_if.slave   wr,
  input  logic              rf_stall,
  output logic              rf_we,
  output addr_t             rf_waddr,
  output data_t             rf_wdata,
  input  addr_t             q_addr1,
  input  addr_t             q_addr2,
  output logic              hit1,
  output logic              hit2,
  output data_t             fwd_data1,
  output data_t             fwd_data2,
  output cnt_t              count,
  output logic              empty
);

  entry_t mem [DEPTH];
  ptr_t   head;
  ptr_t   tail;
  logic   push;
  logic   pop;

  assign empty       = (count == '0);
  assign wr.in_ready = (count < FULL_CNT);

  // Writes to x0 complete the handshake but are dropped.
  assign push = wr.in_valid && wr.in_ready &&
                (wr.in_addr != '0);
  assign pop  = !empty && !rf_stall;

  assign rf_we    = pop;
  assign rf_waddr = empty ? '0 : mem[head].addr;
  assign rf_wdata = empty ? '0 : mem[head].data;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{addr: wr.in_addr,
                     data: wr.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + ptr_t'(1);
      if (pop)  head <= head + ptr_t'(1);
      unique case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  rf_wq_match u_match1 (
    .ents     (mem),
    .head     (head),
    .count    (count),
    .q_addr   (q_addr1),
    .hit      (hit1),
    .fwd_data (fwd_data1)
  );

  rf_wq_match u_match2 (
    .ents     (mem),
    .head     (head),
    .count    (count),
    .q_addr   (q_addr2),
    .hit      (hit2),
    .fwd_data (fwd_data2)
  );

endmodule

// File: tb/tb_rf_write_queue.sv
// tb_rf_write_queue: directed and random stimulus against a queue model.
// Ports: none (top-level bench).
module tb_rf_write_queue;
  import rf_write_queue_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  rf_stall;
  logic  rf_we;
  addr_t rf_waddr;
  data_t rf_wdata;
  addr_t q_addr1, q_addr2;
  logic  hit1, hit2;
  data_t fwd_data1, fwd_data2;
  cnt_t  count;
  logic  empty;

  int errors = 0;
  int checks = 0;

  entry_t mq[$];

  rf_write_queue_if wr ();

  rf_write_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (wr),
    .rf_stall  (rf_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .hit1      (hit1),
    .hit2      (hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h",
               tag, obs, exp);
    end
  endtask

  function automatic void look(input addr_t qa,
                               output logic h,
                               output data_t d);
    h = 1'b0;
    d = '0;
    if (qa != 0)
      foreach (mq[i])
        if (mq[i].addr == qa) begin
          h = 1'b1;
          d = mq[i].data;
        end
  endfunction

  task automatic step(input logic v, input addr_t a,
                      input data_t d, input logic st,
                      input addr_t a1, input addr_t a2,
                      input logic rs);
    logic  e_rdy, e_we, e_h1, e_h2;
    addr_t e_wa;
    data_t e_wd, e_f1, e_f2;
    @(negedge clk);
    wr.in_valid = v;
    wr.in_addr  = a;
    wr.in_data  = d;
    rf_stall    = st;
    q_addr1     = a1;
    q_addr2     = a2;
    rst_n       = rs;
    #1;
    e_rdy = mq.size() < DEPTH;
    e_we  = mq.size() > 0 && !st;
    e_wa  = mq.size() > 0 ? mq[0].addr : '0;
    e_wd  = mq.size() > 0 ? mq[0].data : '0;
    look(a1, e_h1, e_f1);
    look(a2, e_h2, e_f2);
    chk("in_ready", 64'(wr.in_ready), 64'(e_rdy));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(e_wa));
    chk("rf_wdata", rf_wdata, e_wd);
    chk("count", 64'(count), 64'(mq.size()));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("hit1", 64'(hit1), 64'(e_h1));
    chk("fwd1", fwd_data1, e_f1);
    chk("hit2", 64'(hit2), 64'(e_h2));
    chk("fwd2", fwd_data2, e_f2);
    if (!rs) begin
      mq.delete();
    end else begin
      if (e_we) void'(mq.pop_front());
      if (v && e_rdy && a != 0)
        mq.push_back('{addr: a, data: d});
    end
  endtask

  task automatic idle(input logic st);
    step(1'b0, '0, '0, st, '0, '0, 1'b1);
  endtask

  task automatic push(input addr_t a, input data_t d,
                      input logic st);
    step(1'b1, a, d, st, a, '0, 1'b1);
  endtask

  initial begin
    wr.in_valid = 1'b0;
    wr.in_addr  = '0;
    wr.in_data  = '0;
    rf_stall    = 1'b0;
    q_addr1     = '0;
    q_addr2     = '0;
    rst_n       = 1'b0;
    wr.in_valid = 1'b1;
    wr.in_addr  = 5'd3;
    repeat (2) @(posedge clk);
    wr.in_valid = 1'b0;

    // reset state, then single write
    step(1'b0, '0, '0, 1'b0, 5'd3, 5'd5, 1'b1);
    push(5'd5, 64'hAAAA, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // stall with four writes
    for (int i = 1; i <= 4; i++)
      push(addr_t'(i + 8), 64'(i * 16'h1111), 1'b1);
    step(1'b1, 5'd20, 64'hBAD, 1'b1, 5'd9, 5'd12, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // writes to x0 are dropped
    push(5'd0, 64'h1234, 1'b0);
    step(1'b0, '0, '0, 1'b0, 5'd0, 5'd0, 1'b1);

    // same index twice, youngest forwarded
    push(5'd7, 64'h11, 1'b1);
    push(5'd7, 64'h22, 1'b1);
    step(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 1'b1);
    chk("fwd_same_idx", fwd_data1, 64'h22);
    step(1'b0, '0, '0, 1'b0, 5'd7, 5'd0, 1'b1);
    chk("drain_old", rf_wdata, 64'h11);
    step(1'b0, '0, '0, 1'b0, 5'd7, 5'd0, 1'b1);
    chk("drain_new", rf_wdata, 64'h22);
    idle(1'b0);

    // full queue, then sustained push/pop
    for (int i = 0; i < 4; i++)
      push(addr_t'(i + 1), 64'(i + 100), 1'b1);
    for (int i = 0; i < 8; i++)
      push(addr_t'(i + 16), 64'(i + 200), 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // reset with entries queued
    for (int i = 0; i < 3; i++)
      push(addr_t'(i + 2), 64'(i + 300), 1'b1);
    step(1'b1, 5'd9, 64'h99, 1'b0, 5'd2, 5'd3, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 9) < 7,
           addr_t'($urandom_range(0, 7)),
           {$urandom, $urandom},
           $urandom_range(0, 9) < 3,
           addr_t'($urandom_range(0, 7)),
           addr_t'($urandom_range(0, 7)),
           $urandom_range(0, 63) != 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
